// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU placed between issue and writeback.
//
// Single-cycle ops (add/sub, nor/nand, set-less-than, and/or, xor/xnor,
// zero-distance shifts) finish on the acceptance edge. Non-zero shifts move one
// bit per cycle. When the multiplier is built in, it uses shift-add and takes
// one multiplier bit per cycle. A result stays in the output register until
// out_ready takes it.
//
// Build option:
//   ALU_SEQ_MUL_EN  - when defined, adds the iterative multiplier (opcode 101).
//                     When undefined, opcode 101 finishes in one cycle with
//                     out=0 and overflow=1, which marks it as illegal.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid / in_ready  operation handshake (a, b, ctrl, flag)
//   out_valid / out_ready result handshake (out, overflow, carry, zero)
//
// States:
//   state  | meaning
//   IDLE   | empty, waiting for an operation
//   SHIFT  | iterative shift, cnt_q = remaining bit positions
//   MUL    | shift-add multiply, cnt_q = remaining multiplier bits
//   HOLD   | result registered, waiting for out_ready
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  input  logic             flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             carry,
  output logic             zero
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;
  localparam int MSB     = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef ALU_SEQ_MUL_EN
    S_MUL   = 2'd2,
`endif
    S_HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_ctrl_q, op_ctrl_d;
  logic             op_flag_q, op_flag_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ov_q, ov_d;
  logic             cy_q, cy_d;
  logic             zero_q, zero_d;
`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_ov;
`endif

  logic               accept;
  logic               is_shift, is_mul, multi;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum_ext, dif_ext;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ov, sc_cy;
  logic [WIDTH-1:0]   sh_step;
  state_t             accept_state;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      op_ctrl_q <= '0;
      op_flag_q <= 1'b0;
      out_q     <= '0;
      ov_q      <= 1'b0;
      cy_q      <= 1'b0;
      zero_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      op_ctrl_q <= op_ctrl_d;
      op_flag_q <= op_flag_d;
      out_q     <= out_d;
      ov_q      <= ov_d;
      cy_q      <= cy_d;
      zero_q    <= zero_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q     <= acc_d;
`endif
    end
  end

  // ------------------------------------------------------ handshake / decode
  // in_ready is gated by rst so nothing looks acceptable during reset.
  assign in_ready  = !rst && ((state_q == S_IDLE) || (state_q == S_HOLD && out_ready));
  assign out_valid = (state_q == S_HOLD);
  assign accept    = in_valid && in_ready;

  assign shamt    = b[SHAMT_W-1:0];
  assign is_shift = ((ctrl == 3'b011) || (ctrl == 3'b100)) && (shamt != '0);
`ifdef ALU_SEQ_MUL_EN
  assign is_mul   = (ctrl == 3'b101);
`else
  assign is_mul   = 1'b0;
`endif
  assign multi    = is_shift || is_mul;

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign dif_ext = {1'b0, a} - {1'b0, b};

  // Result of an operation that finishes on the acceptance edge.
  always_comb begin
    sc_res = '0;
    sc_ov  = 1'b0;
    sc_cy  = 1'b0;
    case (ctrl)
      3'b000: begin
        if (!flag) begin
          sc_res = sum_ext[WIDTH-1:0];
          sc_cy  = sum_ext[WIDTH];
          sc_ov  = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
        end else begin
          sc_res = dif_ext[WIDTH-1:0];
          sc_cy  = ~dif_ext[WIDTH];  // no borrow: a >= b unsigned
          sc_ov  = (a[MSB] != b[MSB]) && (dif_ext[MSB] != a[MSB]);
        end
      end
      3'b001: sc_res = flag ? ~(a & b) : ~(a | b);
      3'b010: sc_res = {{(WIDTH-1){1'b0}},
                        flag ? ($signed(a) < $signed(b)) : (a < b)};
      3'b011,
      3'b100: sc_res = a;  // only reached with a zero shift distance
      3'b101: begin
`ifndef ALU_SEQ_MUL_EN
        sc_ov = 1'b1;      // multiplier not built: mark as illegal
`endif
        sc_res = '0;
      end
      3'b110: sc_res = flag ? (a | b) : (a & b);
      3'b111: sc_res = flag ? ~(a ^ b) : (a ^ b);
      default: sc_res = '0;
    endcase
  end

  // One bit position of the latched shift operation.
  always_comb begin
    sh_step = sh_q;
    case (op_ctrl_q)
      3'b011:  sh_step = op_flag_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
      3'b100:  sh_step = op_flag_q ? {sh_q[0], sh_q[WIDTH-1:1]} : {sh_q[MSB], sh_q[WIDTH-1:1]};
      default: sh_step = sh_q;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // Shift-add multiply. acc_q = {partial high, unused multiplier bits}. sh_q
  // holds the multiplicand.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, sh_q} : '0);
  assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_res  = op_flag_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
  assign mul_ov   = op_flag_q ? (acc_step[WIDTH-1:0] != '0)
                              : (acc_step[2*WIDTH-1:WIDTH] != '0);
`endif

  // --------------------------------------------------------------- next state
  always_comb begin
    accept_state = S_HOLD;
    if (is_shift) accept_state = S_SHIFT;
`ifdef ALU_SEQ_MUL_EN
    if (is_mul) accept_state = S_MUL;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = accept_state;
      S_SHIFT: if (cnt_q == CNT_W'(1)) state_d = S_HOLD;
`ifdef ALU_SEQ_MUL_EN
      S_MUL:   if (cnt_q == CNT_W'(1)) state_d = S_HOLD;
`endif
      S_HOLD: begin
        if (accept)         state_d = accept_state;
        else if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- datapath / outputs
  always_comb begin
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    op_ctrl_d = op_ctrl_q;
    op_flag_d = op_flag_q;
    out_d     = out_q;
    ov_d      = ov_q;
    cy_d      = cy_q;
    zero_d    = zero_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d     = acc_q;
`endif
    if (accept) begin
      op_ctrl_d = ctrl;
      op_flag_d = flag;
      sh_d      = a;
      cnt_d     = is_mul ? CNT_W'(WIDTH) : {1'b0, shamt};
`ifdef ALU_SEQ_MUL_EN
      acc_d     = {{WIDTH{1'b0}}, b};
`endif
      if (!multi) begin
        out_d  = sc_res;
        ov_d   = sc_ov;
        cy_d   = sc_cy;
        zero_d = (sc_res == '0);
      end
    end else if (state_q == S_SHIFT) begin
      sh_d  = sh_step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        out_d  = sh_step;
        ov_d   = 1'b0;
        cy_d   = 1'b0;
        zero_d = (sh_step == '0);
      end
`ifdef ALU_SEQ_MUL_EN
    end else if (state_q == S_MUL) begin
      acc_d = acc_step;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        out_d  = mul_res;
        ov_d   = mul_ov;
        cy_d   = 1'b0;
        zero_d = (mul_res == '0);
      end
`endif
    end
  end

  assign out      = out_q;
  assign overflow = ov_q;
  assign carry    = cy_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  ctrl = '0;
  logic        flag = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out;
  logic        overflow, carry, zero;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ctrl(ctrl), .flag(flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .overflow(overflow), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure edges from acceptance to out_valid, check, drain.
  task automatic run_op(input string tag, input logic [2:0] c, input logic f,
                        input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ex_out, input logic ex_ov,
                        input logic ex_cy, input int ex_lat);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; ctrl = c; flag = f; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); ctrl = 3'($urandom);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(ex_lat));
    chk({tag, ".out"}, {16'd0, out}, {16'd0, ex_out});
    chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, ex_ov});
    chk({tag, ".carry"}, {31'd0, carry}, {31'd0, ex_cy});
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, (ex_out == 16'h0000)});
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, ".drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    logic        seen;

    // reset state
    #2;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out", {16'd0, out}, 32'd0);
    chk("rst.flags", {29'd0, overflow, carry, zero}, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rst.release_ready", {31'd0, in_ready}, 32'd1);

    // arithmetic
    run_op("add_ovf",   3'b000, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 0);
    run_op("add_carry", 3'b000, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 0);
    run_op("sub_neg",   3'b000, 1'b1, 16'h000A, 16'h000F, 16'hFFFB, 1'b0, 1'b0, 0);
    run_op("sub_pos",   3'b000, 1'b1, 16'h000F, 16'h000A, 16'h0005, 1'b0, 1'b1, 0);
    run_op("sub_sovf",  3'b000, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 0);
    // compare
    run_op("slt",  3'b010, 1'b1, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 0);
    run_op("sltu", 3'b010, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 0);
    // logic
    run_op("nor",  3'b001, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 0);
    run_op("nand", 3'b001, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0);
    run_op("and",  3'b110, 1'b0, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 0);
    run_op("or",   3'b110, 1'b1, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 1'b0, 0);
    run_op("xor",  3'b111, 1'b0, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b0, 0);
    run_op("xnor", 3'b111, 1'b1, 16'hF0F0, 16'h0FF0, 16'h00FF, 1'b0, 1'b0, 0);
    // shifts (upper bits of b ignored)
    run_op("sra3",   3'b100, 1'b0, 16'hF000, 16'h0013, 16'hFE00, 1'b0, 1'b0, 3);
    run_op("sra_pos",3'b100, 1'b0, 16'h4000, 16'h0002, 16'h1000, 1'b0, 1'b0, 2);
    run_op("ror1",   3'b100, 1'b1, 16'h0001, 16'h0001, 16'h8000, 1'b0, 1'b0, 1);
    run_op("ror2",   3'b100, 1'b1, 16'h0003, 16'hFFF2, 16'hC000, 1'b0, 1'b0, 2);
    run_op("sll0",   3'b011, 1'b1, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 0);
    run_op("sll4",   3'b011, 1'b1, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0, 4);
    run_op("srl15",  3'b011, 1'b0, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 15);
    run_op("srl_z",  3'b011, 1'b0, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1);
    // multiply
`ifdef ALU_SEQ_MUL_EN
    run_op("mul_lo",   3'b101, 1'b0, 16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b0, 16);
    run_op("mul_lo_ov",3'b101, 1'b0, 16'h1000, 16'h0010, 16'h0000, 1'b1, 1'b0, 16);
    run_op("mul_hi",   3'b101, 1'b1, 16'h1000, 16'h0010, 16'h0001, 1'b0, 1'b0, 16);
    run_op("mul_ff",   3'b101, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0, 16);
`else
    run_op("mul_off",  3'b101, 1'b0, 16'h0123, 16'h0010, 16'h0000, 1'b1, 1'b0, 0);
`endif

    // backpressure, then drain + accept on the same edge
    @(negedge clk);
    in_valid = 1'b1; ctrl = 3'b000; flag = 1'b0; a = 16'h0001; b = 16'h0002;
    @(posedge clk); #1; in_valid = 1'b0;
    chk("bp.valid", {31'd0, out_valid}, 32'd1);
    held = out;
    chk("bp.out", {16'd0, held}, 32'h0003);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.hold_out", {16'd0, out}, 32'h0003);
      chk("bp.hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; ctrl = 3'b111; flag = 1'b0;
    a = 16'h00FF; b = 16'h0F0F;
    #1 chk("bp.ready_same_cycle", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp.next_out", {16'd0, out}, 32'h0FF0);
    // out_ready still high: drains now
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp.drained", {31'd0, out_valid}, 32'd0);

    // throughput: back-to-back single-cycle ops with out_ready high
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; ctrl = 3'b000; flag = 1'b0;
    a = 16'h0010; b = 16'h0020;
    @(posedge clk); #1;
    chk("tp.first", {16'd0, out}, 32'h0030);
    a = 16'h0100; b = 16'h0001;
    @(posedge clk); #1;
    chk("tp.second", {16'd0, out}, 32'h0101);
    chk("tp.valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1; out_ready = 1'b0;

    // reset in the middle of SRL by 15
    @(negedge clk);
    in_valid = 1'b1; ctrl = 3'b011; flag = 1'b0; a = 16'h8000; b = 16'h000F;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort.out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort.out", {16'd0, out}, 32'd0);
    chk("abort.flags", {29'd0, overflow, carry, zero}, 32'd0);
    chk("abort.in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("abort.release_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort.no_result", {31'd0, seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
